led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter CHANNELS, 4, number of independent LED channels (1..16) SHALL be supported.
REQ-002 Parameter CLK_HZ, 20000000, SHALL give the input clock frequency in Hz.
REQ-003 Parameter TICK_HZ, 1000, SHALL give the blink time-base tick rate in Hz; TICK_DIV = CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-004 Parameter CNT_W, 16, SHALL give the width of the period and duty fields.
REQ-005 Port list SHALL be, in order:
- CLK20MHZ  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CFG_VALID  in  1  config write request.
- CFG_READY  out  1  config write can be accepted.
- CFG_CH  in  max(1,$clog2(CHANNELS))  target channel.
- CFG_MODE  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
- CFG_PERIOD  in  CNT_W  BLINK half-period in ticks / PWM period in clocks.
- CFG_DUTY  in  CNT_W  PWM high time in clocks; ignored in other modes.
- CFG_ERR  out  1  one-cycle pulse: write rejected.
- TICK  out  1  one-cycle time-base pulse.
- LED_OUT  out  CHANNELS  per-channel LED drive, registered.

Function
REQ-006 A prescaler SHALL count 0..TICK_DIV-1 and wrap; TICK SHALL be 1 exactly in the cycle the count equals TICK_DIV-1.
REQ-007 CFG_READY SHALL be 1 in every non-reset cycle except the one cycle immediately after an accepted write.
REQ-008 A write SHALL be accepted when CFG_VALID && CFG_READY; with CFG_CH < CHANNELS it SHALL latch mode, period, duty into that channel.
REQ-009 A write with CFG_CH >= CHANNELS SHALL change no state and SHALL pulse CFG_ERR for one cycle, in the cycle after acceptance.
REQ-010 A latched CFG_PERIOD of 0 SHALL be stored as 1; CFG_DUTY SHALL be used unchanged.
REQ-011 On an accepted write the channel's phase counter SHALL be cleared to 0; LED_OUT for that channel SHALL reflect the new mode from the cycle after acceptance.
REQ-012 OFF: LED_OUT[ch] SHALL be 0. ON: LED_OUT[ch] SHALL be 1.
REQ-013 BLINK: LED_OUT[ch] SHALL start at 1; the phase counter SHALL advance only on TICK; on the TICK where phase == PERIOD-1, phase SHALL wrap to 0 and LED_OUT[ch] SHALL toggle.
REQ-014 PWM: phase SHALL advance every clock and wrap from PERIOD-1 to 0; LED_OUT[ch] SHALL be 1 when phase < DUTY, else 0. DUTY >= PERIOD SHALL give constant 1; DUTY = 0 SHALL give constant 0.
REQ-015 A write and a TICK in the same cycle for the same channel SHALL apply the write; the tick SHALL be lost for that channel only.
REQ-016 Channels SHALL be fully independent except for the shared prescaler.
REQ-017 Phase counters SHALL be CNT_W bits and SHALL never exceed PERIOD-1.

Reset
REQ-018 RESET SHALL have priority over all inputs, including an in-progress write.
REQ-019 While RESET is 1 and in the first cycle after: CFG_READY=0, CFG_ERR=0, TICK=0, LED_OUT=0.
REQ-020 Reset SHALL set every channel to OFF, period 1, duty 0, phase 0, and the prescaler to 0.
REQ-021 Reset asserted mid-blink or mid-PWM SHALL take effect in the next cycle with no residual output.

Structure
REQ-022 Package led_pattern_pkg SHALL hold the 2-bit mode type and its four encodings, and the parameter defaults.
REQ-023 The per-channel mode/phase/output logic SHALL be one sub-module, led_channel, instantiated CHANNELS times.
REQ-024 The prescaler, the config handshake and the error flag SHALL reside in led_pattern_gen.

Verification
REQ-025 The bench SHALL use CLK_HZ=20, TICK_HZ=2 (TICK_DIV=10), CHANNELS=4, CNT_W=8.
REQ-026 Reset release, no writes -> TICK pulses every 10 cycles; LED_OUT=4'b0000; CFG_READY=1 from the 2nd cycle.
REQ-027 Write ch1 BLINK period 3 -> LED_OUT[1]=1, then toggles every 30 clocks, aligned to TICK; other bits 0.
REQ-028 Write ch2 PWM period 4 duty 1 -> LED_OUT[2] repeats 1,0,0,0; then duty 9 -> constant 1; then duty 0 -> constant 0.
REQ-029 CFG_VALID held high across two writes (ch0 ON, ch3 OFF) -> second write accepted one cycle later (READY gap); write ch=5 is illegal for CHANNELS=4, but CFG_CH is only 2 bits wide, so the bench SHALL instead use CHANNELS=3 with ch=3 -> CFG_ERR pulses once and no LED_OUT changes.
REQ-030 RESET for 1 cycle during ch1 BLINK high phase -> LED_OUT=0 next cycle; channel stays OFF until rewritten.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and parameter defaults for the LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_CLK_HZ   = 20000000;
  localparam int DEF_TICK_HZ  = 1000;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/led_channel.sv
// One LED channel: latched mode/period/duty, phase counter and registered drive.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  input  logic             i_tick,
  output logic             o_led
);

  led_mode_e        r_mode;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_phase;
  logic             r_led;

  led_mode_e        w_mode;
  logic [CNT_W-1:0] w_period_in;
  logic             w_phase_last;
  logic [CNT_W-1:0] w_phase_nxt;

  assign w_mode       = led_mode_e'(i_mode);
  // A zero period would make the wrap compare underflow, so it is held at 1.
  assign w_period_in  = (i_period == '0) ? CNT_W'(1) : i_period;
  assign w_phase_last = (r_phase == (r_period - CNT_W'(1)));
  assign w_phase_nxt  = w_phase_last ? '0 : (r_phase + CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode   <= MODE_OFF;
      r_period <= CNT_W'(1);
      r_duty   <= '0;
      r_phase  <= '0;
      r_led    <= 1'b0;
    end else if (i_we) begin
      r_mode   <= w_mode;
      r_period <= w_period_in;
      r_duty   <= i_duty;
      r_phase  <= '0;
      case (w_mode)
        MODE_OFF:   r_led <= 1'b0;
        MODE_ON:    r_led <= 1'b1;
        MODE_BLINK: r_led <= 1'b1;
        MODE_PWM:   r_led <= (i_duty != '0);
      endcase
    end else begin
      case (r_mode)
        MODE_OFF: r_led <= 1'b0;
        MODE_ON:  r_led <= 1'b1;
        MODE_BLINK: begin
          if (i_tick) begin
            r_phase <= w_phase_nxt;
            if (w_phase_last) r_led <= ~r_led;
          end
        end
        // Output is computed from the phase being loaded so led always matches phase < duty.
        MODE_PWM: begin
          r_phase <= w_phase_nxt;
          r_led   <= (w_phase_nxt < r_duty);
        end
      endcase
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config handshake, error flag.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int TICK_HZ  = DEF_TICK_HZ,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                                            CLK20MHZ,
  input  logic                                            RESET,
  input  logic                                            CFG_VALID,
  output logic                                            CFG_READY,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] CFG_CH,
  input  logic [1:0]                                      CFG_MODE,
  input  logic [CNT_W-1:0]                                CFG_PERIOD,
  input  logic [CNT_W-1:0]                                CFG_DUTY,
  output logic                                            CFG_ERR,
  output logic                                            TICK,
  output logic [CHANNELS-1:0]                             LED_OUT
);

  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);

  logic [PRE_W-1:0]    r_presc;
  logic                r_ready;
  logic                r_err;

  logic                w_tick;
  logic                w_accept;
  logic                w_ch_ok;
  logic [CHANNELS-1:0] w_led;

  assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge CLK20MHZ) begin
    if (RESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  assign w_accept = CFG_VALID && r_ready;
  assign w_ch_ok  = (32'(CFG_CH) < CHANNELS);

  // Ready is low out of reset and for one cycle after every accepted write.
  always_ff @(posedge CLK20MHZ) begin
    if (RESET) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= !w_accept;
      r_err   <= w_accept && !w_ch_ok;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic w_we;
    assign w_we = w_accept && (CFG_CH == CH_W'(i));

    led_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .i_clk   (CLK20MHZ),
      .i_rst   (RESET),
      .i_we    (w_we),
      .i_mode  (CFG_MODE),
      .i_period(CFG_PERIOD),
      .i_duty  (CFG_DUTY),
      .i_tick  (w_tick),
      .o_led   (w_led[i])
    );
  end

  assign CFG_READY = r_ready;
  assign CFG_ERR   = r_err;
  assign TICK      = w_tick;
  assign LED_OUT   = w_led;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Drives a 4-channel and a 3-channel generator with shared stimulus, checked against a time-based model.
module tb_led_pattern_gen;

  localparam int CNT_W   = 8;
  localparam int CLK_HZ  = 20;
  localparam int TICK_HZ = 2;
  localparam int TDIV    = CLK_HZ / TICK_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] ch = 2'd0;
  logic [1:0] mode = 2'd0;
  logic [7:0] per = 8'd0;
  logic [7:0] duty = 8'd0;

  logic       rdy4, err4, tick4;
  logic [3:0] led4;
  logic       rdy3, err3, tick3;
  logic [2:0] led3;

  always #5 clk = ~clk;

  led_pattern_gen #(.CHANNELS(4), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CNT_W(CNT_W)) dut4 (
    .CLK20MHZ(clk), .RESET(rst), .CFG_VALID(valid), .CFG_READY(rdy4), .CFG_CH(ch),
    .CFG_MODE(mode), .CFG_PERIOD(per), .CFG_DUTY(duty), .CFG_ERR(err4), .TICK(tick4),
    .LED_OUT(led4)
  );

  led_pattern_gen #(.CHANNELS(3), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CNT_W(CNT_W)) dut3 (
    .CLK20MHZ(clk), .RESET(rst), .CFG_VALID(valid), .CFG_READY(rdy3), .CFG_CH(ch),
    .CFG_MODE(mode), .CFG_PERIOD(per), .CFG_DUTY(duty), .CFG_ERR(err3), .TICK(tick3),
    .LED_OUT(led3)
  );

  // Model: each channel remembers when it was written and derives its output from elapsed time.
  int m_age [2];
  bit m_rdy [2];
  bit m_err [2];
  int m_mode  [2][4];
  int m_per   [2][4];
  int m_duty  [2][4];
  int m_since [2][4];
  bit m_live = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_led(input int d, input int c);
    case (m_mode[d][c])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((m_since[d][c] / m_per[d][c]) % 2) == 0;
      default: return (m_since[d][c] % m_per[d][c]) < m_duty[d][c];
    endcase
  endfunction

  task automatic check_all();
    logic [3:0] exp4;
    logic [2:0] exp3;
    for (int c = 0; c < 4; c++) exp4[c] = model_led(0, c);
    for (int c = 0; c < 3; c++) exp3[c] = model_led(1, c);
    chk("tick4",  32'(tick4), 32'((m_age[0] % TDIV) == TDIV - 1));
    chk("ready4", 32'(rdy4),  32'(m_rdy[0]));
    chk("err4",   32'(err4),  32'(m_err[0]));
    chk("led4",   32'(led4),  32'(exp4));
    chk("tick3",  32'(tick3), 32'((m_age[1] % TDIV) == TDIV - 1));
    chk("ready3", 32'(rdy3),  32'(m_rdy[1]));
    chk("err3",   32'(err3),  32'(m_err[1]));
    chk("led3",   32'(led3),  32'(exp3));
  endtask

  task automatic advance(input int d, input int n);
    bit acc;
    bit tk;
    if (rst) begin
      m_age[d] = 0;
      m_rdy[d] = 1'b0;
      m_err[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_mode[d][c] = 0; m_per[d][c] = 1; m_duty[d][c] = 0; m_since[d][c] = 0;
      end
    end else begin
      acc = valid && m_rdy[d];
      tk  = (m_age[d] % TDIV) == TDIV - 1;
      for (int c = 0; c < n; c++) begin
        if (acc && int'(ch) == c) begin
          m_mode[d][c]  = int'(mode);
          m_per[d][c]   = (per == 8'd0) ? 1 : int'(per);
          m_duty[d][c]  = int'(duty);
          m_since[d][c] = 0;
        end else if ((m_mode[d][c] == 2 && tk) || m_mode[d][c] == 3) begin
          m_since[d][c]++;
        end
      end
      m_err[d] = acc && (int'(ch) >= n);
      m_rdy[d] = !acc;
      m_age[d]++;
    end
  endtask

  task automatic cyc(input bit r, input bit v, input int c, input int md, input int p, input int du);
    @(negedge clk);
    if (m_live) check_all();
    rst = r; valid = v; ch = 2'(c); mode = 2'(md); per = 8'(p); duty = 8'(du);
    advance(0, 4);
    advance(1, 3);
    m_live = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) cyc(1'b1, 1'b0, 0, 0, 0, 0);
    idle(25);
    cyc(1'b0, 1'b1, 1, 2, 3, 0);
    idle(70);
    cyc(1'b0, 1'b1, 2, 3, 4, 1);
    idle(12);
    cyc(1'b0, 1'b1, 2, 3, 4, 9);
    idle(8);
    cyc(1'b0, 1'b1, 2, 3, 4, 0);
    idle(8);
    cyc(1'b0, 1'b1, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 3, 0, 0, 0);
    cyc(1'b0, 1'b1, 3, 0, 0, 0);
    idle(5);
    cyc(1'b0, 1'b1, 1, 2, 3, 0);
    idle(5);
    cyc(1'b1, 1'b0, 0, 0, 0, 0);
    idle(40);
    cyc(1'b0, 1'b1, 0, 3, 0, 255);
    idle(6);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 399) == 0,
          $urandom_range(0, 7) == 0,
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 6)),
          ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 7)));
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
